// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// One radix-2 iteration of the MDU datapath (purely combinational).
// Mult: {hi,lo} = {acc,mplier}; conditional add of the multiplicand, then shift right.
// Div : {hi,lo} = {rem,quot};   shift left, trial subtract of the divisor, restore on borrow.
module mult_div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] wh,
  input  logic [WIDTH-1:0] wl,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nwh,
  output logic [WIDTH-1:0] nwl
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // select mult or div step; carry of the add lands in the top bit before the shift
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    nwh     = wh;
    nwl     = wl;
    if (!is_div) begin
      sum = wl[0] ? ({1'b0, wh} + {1'b0, opnd}) : {1'b0, wh};
      nwh = sum[WIDTH:1];
      nwl = {sum[0], wl[WIDTH-1:1]};
    end else begin
      shifted = {wh, wl[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      if (!diff[WIDTH]) begin
        nwh = diff[WIDTH-1:0];
        nwl = {wl[WIDTH-2:0], 1'b1};
      end else begin
        nwh = shifted[WIDTH-1:0];
        nwl = {wl[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO. Operates on magnitudes,
// fixes signs in FINISH. Latency: start edge -> done pulse WIDTH+2 cycles later.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mult_div_unit_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_e           state, nstate;
  logic [CW-1:0]    cnt;
  logic             is_div, sa, sb;
  logic [WIDTH-1:0] wh, wl, opnd;
  logic [WIDTH-1:0] nwh, nwl;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  mult_div_unit_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .wh     (wh),
    .wl     (wl),
    .opnd   (opnd),
    .nwh    (nwh),
    .nwl    (nwl)
  );

  // operand magnitudes and final sign correction; divide-by-zero forces LO to all ones,
  // while the remainder path naturally reproduces a in HI
  always_comb begin
    a_neg    = op_is_signed(op) & a[WIDTH-1];
    b_neg    = op_is_signed(op) & b[WIDTH-1];
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
    prod_fix = (sa ^ sb) ? -{wh, wl} : {wh, wl};
    quot_fix = (opnd == '0) ? '1 : ((sa ^ sb) ? -wl : wl);
    rem_fix  = sa ? -wh : wh;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (start) nstate = S_RUN;
      S_RUN:    if (cnt == '0) nstate = S_FINISH;
      S_FINISH: nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // operand capture at start, one iteration per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      wh     <= '0;
      wl     <= '0;
      opnd   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt    <= CW'(WIDTH-1);
          is_div <= op_is_div(op);
          sa     <= a_neg;
          sb     <= b_neg;
          wh     <= '0;
          wl     <= op_is_div(op) ? a_abs : b_abs;
          opnd   <= op_is_div(op) ? b_abs : a_abs;
        end
        S_RUN: begin
          wh  <= nwh;
          wl  <= nwl;
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result load in FINISH, MTHI/MTLO only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_FINISH);
      if (state == S_FINISH) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else if (state == S_IDLE) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: stimulus pushes expected {hi,lo},
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] expq[$];
  bit          stim_done = 1'b0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] eh, input logic [31:0] el);
    expq.push_back({eh, el});
  endtask

  // returns one cycle after the start edge (cycle 1)
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // returns in the done cycle (or after the bound expires)
  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  // monitor: compare every done pulse against the oldest expectation
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no pending result", hi, lo);
        end else begin
          e = expq.pop_front();
          chk("result_hi", hi, e[63:32]);
          chk("result_lo", lo, e[31:0]);
        end
      end
    end
  end

  initial begin
    int bad;
    int extra;

    // reset state
    repeat (2) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;
    tick();

    // MULTU max*max with exact latency checks
    push(32'hFFFFFFFE, 32'h00000001);
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    chk("busy_window_bad_cycles", bad, 32'd0);
    chk("done_at_34", {31'd0, done}, 32'd1);
    chk("busy_low_at_34", {31'd0, busy}, 32'd0);

    // back-to-back starts issued in each done cycle
    push(32'hFFFFFFFF, 32'hFFFFFFEB);
    start_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done("mult_neg");
    push(32'h40000000, 32'h00000000);
    start_op(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done("mult_min");
    push(32'hFFFFFFFF, 32'hFFFFFFFD);
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg");
    push(32'd2, 32'd14);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu");
    push(32'h00001234, 32'hFFFFFFFF);
    start_op(OP_DIV, 32'h00001234, 32'd0);
    wait_done("div_zero");
    push(32'hFFFFFFF9, 32'hFFFFFFFF);
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd0);
    wait_done("div_zero_neg");
    push(32'h00000000, 32'h80000000);
    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf");

    // start + mthi while busy are ignored
    push(32'd2, 32'd14);
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    op = OP_MULTU; a = 32'd5; b = 32'd5; start = 1'b1; mthi = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0; mthi = 1'b0;
    wait_done("busy_ignore");
    extra = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) extra++;
    end
    chk("no_second_done", extra, 32'd0);

    // async reset mid-operation
    start_op(OP_MULT, 32'd7, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(32'd2, 32'd14);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done("after_rst");
    tick();

    // MTLO in idle, then MTHI together with start
    wdata = 32'hA5A5A5A5; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'hA5A5A5A5);
    chk("mtlo_hi_kept", hi, 32'd2);
    wdata = 32'h11112222; mthi = 1'b1;
    push(32'd0, 32'd6);
    start_op(OP_MULTU, 32'd2, 32'd3);
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'h11112222);
    chk("mthi_lo_kept", lo, 32'hA5A5A5A5);
    chk("mthi_start_busy", {31'd0, busy}, 32'd1);
    wait_done("mthi_start");
    repeat (3) tick();

    chk("pending_results", expq.size(), 32'd0);
    stim_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global bound so the run always ends
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL global_timeout: got no completion, required finish within bound");
      $fatal(1, "timeout");
    end
  end

endmodule
